// File: rtl/attitude_pkg.sv
// rtl/attitude_pkg.sv - shared attitude word bit positions and reset value
package attitude_pkg;
  localparam int ROLL_SGN  = 3;
  localparam int PITCH_SGN = 2;
  localparam int ROLL_LVL  = 1;
  localparam int PITCH_LVL = 0;

  localparam logic [3:0] ATT_LEVEL = 4'b0011;
endpackage

// File: rtl/axis_level_detector.sv
// rtl/axis_level_detector.sv - per-axis saturating |x| with hysteresis level compare
module axis_level_detector #(
  parameter int DATA_W     = 16,
  parameter int FRAC_BITS  = 4,
  parameter int THRESH_DEG = 10,
  parameter int HYST_DEG   = 2
) (
  input  logic [DATA_W-1:0] i_Sample,
  input  logic              i_Level_Committed,
  output logic              o_Sign,
  output logic              o_Level
);

  localparam logic [DATA_W-1:0] T_LO    = DATA_W'((THRESH_DEG - HYST_DEG) << FRAC_BITS);
  localparam logic [DATA_W-1:0] T_HI    = DATA_W'((THRESH_DEG + HYST_DEG) << FRAC_BITS);
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};

  logic [DATA_W-1:0] abs_val;

  always_comb begin
    abs_val = i_Sample;
    // Negating the most negative value would wrap back to itself, so clamp it.
    if (i_Sample == MOST_NEG) begin
      abs_val = MOST_POS;
    end else if (i_Sample[DATA_W-1]) begin
      abs_val = -i_Sample;
    end
  end

  always_comb begin
    o_Sign  = i_Sample[DATA_W-1];
    o_Level = i_Level_Committed;
    if (i_Level_Committed) begin
      if (abs_val > T_HI) o_Level = 1'b0;
    end else begin
      if (abs_val <= T_LO) o_Level = 1'b1;
    end
  end

endmodule

// File: rtl/attitude_encoder_hyst.sv
// rtl/attitude_encoder_hyst.sv - roll/pitch attitude encoder with hysteresis and persistence filter
module attitude_encoder_hyst
  import attitude_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FRAC_BITS  = 4,
  parameter int THRESH_DEG = 10,
  parameter int HYST_DEG   = 2,
  parameter int PERSIST    = 4
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Valid,
  input  logic [DATA_W-1:0] i_Roll_Raw,
  input  logic [DATA_W-1:0] i_Pitch_Raw,
  output logic              o_Valid,
  output logic [3:0]        o_Attitude,
  output logic              o_Changed
);

  localparam int CNT_W = $clog2(PERSIST + 1);

  generate
    if (HYST_DEG < 0 || HYST_DEG >= THRESH_DEG || PERSIST < 1) begin : g_bad_params
      $error("attitude_encoder_hyst: need 0 <= HYST_DEG < THRESH_DEG and PERSIST >= 1");
    end
  endgenerate

  logic [3:0]       committed_q, committed_d;
  logic [3:0]       pending_q, pending_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             changed_q, changed_d;
  logic [3:0]       cand;

  axis_level_detector #(
    .DATA_W(DATA_W), .FRAC_BITS(FRAC_BITS), .THRESH_DEG(THRESH_DEG), .HYST_DEG(HYST_DEG)
  ) u_roll (
    .i_Sample         (i_Roll_Raw),
    .i_Level_Committed(committed_q[ROLL_LVL]),
    .o_Sign           (cand[ROLL_SGN]),
    .o_Level          (cand[ROLL_LVL])
  );

  axis_level_detector #(
    .DATA_W(DATA_W), .FRAC_BITS(FRAC_BITS), .THRESH_DEG(THRESH_DEG), .HYST_DEG(HYST_DEG)
  ) u_pitch (
    .i_Sample         (i_Pitch_Raw),
    .i_Level_Committed(committed_q[PITCH_LVL]),
    .o_Sign           (cand[PITCH_SGN]),
    .o_Level          (cand[PITCH_LVL])
  );

  always_comb begin
    committed_d = committed_q;
    pending_d   = pending_q;
    cnt_d       = cnt_q;
    valid_d     = i_Valid;
    changed_d   = 1'b0;
    if (i_Valid) begin
      if (cand == committed_q) begin
        pending_d = committed_q;
        cnt_d     = '0;
      end else if (cand == pending_q) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        pending_d = cand;
        cnt_d     = CNT_W'(1);
      end
      // Commit in the same update that reaches the count, so cnt never exceeds PERSIST.
      if (cnt_d >= CNT_W'(PERSIST)) begin
        committed_d = pending_d;
        cnt_d       = '0;
        changed_d   = (pending_d != committed_q);
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      committed_q <= ATT_LEVEL;
      pending_q   <= ATT_LEVEL;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      changed_q   <= 1'b0;
    end else begin
      committed_q <= committed_d;
      pending_q   <= pending_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      changed_q   <= changed_d;
    end
  end

  assign o_Valid    = valid_q;
  assign o_Attitude = committed_q;
  assign o_Changed  = changed_q;

endmodule

// File: doc/attitude_encoder_hyst.md
ATTITUDE_ENCODER_HYST -- requirements
Module: attitude_encoder_hyst

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning the width of the signed two's-complement raw roll/pitch samples.
REQ-002 The block SHALL have parameter FRAC_BITS, default 4, meaning LSBs per degree as a power of two (16 LSB = 1 deg).
REQ-003 The block SHALL have parameter THRESH_DEG, default 10, meaning the nominal level threshold in whole degrees.
REQ-004 The block SHALL have parameter HYST_DEG, default 2, meaning the half-width of the hysteresis band in degrees; the block SHALL accept only 0 <= HYST_DEG < THRESH_DEG.
REQ-005 The block SHALL have parameter PERSIST, default 4, meaning the number of consecutive identical valid samples (>= 1) required to commit a new attitude.
REQ-006 The block SHALL have port i_Clk, input, 1 bit: the single clock, all logic on its rising edge.
REQ-007 The block SHALL have port i_Rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 The block SHALL have port i_Valid, input, 1 bit: roll/pitch sample present this cycle.
REQ-009 The block SHALL have port i_Roll_Raw, input, DATA_W bits: signed roll sample.
REQ-010 The block SHALL have port i_Pitch_Raw, input, DATA_W bits: signed pitch sample.
REQ-011 The block SHALL have port o_Valid, output, 1 bit: one-cycle pulse, o_Attitude updated for the sample.
REQ-012 The block SHALL have port o_Attitude, output, 4 bits: committed [sgn(roll), sgn(pitch), isLevel(roll), isLevel(pitch)].
REQ-013 The block SHALL have port o_Changed, output, 1 bit: pulses with o_Valid when the committed attitude changed on that sample.

Function
REQ-014 Each axis SHALL compute |x| in DATA_W bits, treating the input as signed; the most negative input SHALL saturate to 2^(DATA_W-1)-1 and SHALL NOT wrap.
REQ-015 Thresholds SHALL be constants: T_LO = (THRESH_DEG-HYST_DEG)<<FRAC_BITS and T_HI = (THRESH_DEG+HYST_DEG)<<FRAC_BITS, with defaults 128 and 192.
REQ-016 The candidate isLevel SHALL use the committed isLevel of its axis: if committed level, the candidate is 0 only when |x| > T_HI; if committed not level, the candidate is 1 only when |x| <= T_LO; otherwise the candidate SHALL hold the committed value.
REQ-017 The candidate sign bit SHALL equal the input MSB, so an input of 0 SHALL yield sign 0.
REQ-018 The four candidate bits SHALL be evaluated as a single 4-bit word (cand) on each i_Valid cycle; the block SHALL ignore all inputs when i_Valid=0.
REQ-019 Persistence on each valid sample: if cand == committed, the block SHALL set pending := committed and cnt := 0.
REQ-020 Persistence on each valid sample: else if cand == pending, the block SHALL set cnt := cnt+1.
REQ-021 Persistence on each valid sample: else the block SHALL set pending := cand and cnt := 1.
REQ-022 When the resulting cnt >= PERSIST, the block SHALL set committed := pending and cnt := 0 in that same update; with PERSIST=1 the first differing sample SHALL commit.
REQ-023 cnt SHALL be ceil(log2(PERSIST+1)) bits wide and SHALL never exceed PERSIST.
REQ-024 Latency SHALL be exactly 1 cycle: o_Valid is asserted the cycle after i_Valid, with o_Attitude reflecting that sample's update; back-to-back i_Valid SHALL produce back-to-back o_Valid.
REQ-025 o_Attitude SHALL change only in a cycle where o_Valid=1, and SHALL hold its value otherwise.
REQ-026 o_Changed SHALL be 1 only when o_Valid=1 and a commit altered o_Attitude.

Reset
REQ-027 On i_Rst=1 at a clock edge, the block SHALL set committed and pending to 4'b0011, cnt to 0, o_Valid to 0 and o_Changed to 0.
REQ-028 i_Rst SHALL take priority over i_Valid in the same cycle; that sample SHALL be dropped and produce no o_Valid.
REQ-029 A reset mid-persistence SHALL discard the partial count.

Structure
REQ-030 A shared package attitude_pkg SHALL hold the attitude bit-index constants (ROLL_SGN=3, PITCH_SGN=2, ROLL_LVL=1, PITCH_LVL=0) and the reset value ATT_LEVEL=4'b0011.
REQ-031 One sub-module axis_level_detector (saturating abs plus hysteresis compare, combinational) SHALL be instantiated once per axis.
REQ-032 The persistence logic and output registers SHALL live in the top module.

Verification
REQ-033 Reset: assert i_Rst -> o_Attitude=0011, o_Valid=0, o_Changed=0.
REQ-034 Roll=+200, pitch=0, 4 valid samples -> o_Attitude stays 0011 on the first 3 o_Valid; the 4th gives 0001 with o_Changed=1.
REQ-035 Hysteresis: from roll non-level, roll=160 for 10 samples -> roll bit1 stays 0; then roll=128 for 4 samples -> bit1=1 on the 4th sample.
REQ-036 Roll=16'h8000 for 4 samples -> o_Attitude=1001 (sign 1, not level), with no wrap to level.
REQ-037 Flicker: roll alternates 200/0 on every sample for 20 samples -> o_Attitude stays 0011 and o_Changed never asserts.
REQ-038 Reset mid-persistence: 3 samples of roll=200, then i_Rst, then 1 sample of 200 -> o_Attitude=0011 with no commit.
